// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes, FSM states and width helpers for alu_pipe.
package alu_pipe_pkg;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } op_e;
    typedef enum logic {S_IDLE, S_MUL} state_e;
    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/alu_pipe_comb.sv
// alu_pipe_comb: single-cycle result, carry, overflow and illegal decode; MUL is legal here only with ALU_PIPE_MUL_EN.
module alu_pipe_comb
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);
    localparam int SHAMT_W = shamt_w(WIDTH);
    logic             is_sub;
    logic             arith;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [SHAMT_W-1:0] shamt;
    assign is_sub = op == OP_SUB;
    assign arith  = is_sub || op == OP_ADD;
    assign bx     = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    assign shamt  = b[SHAMT_W-1:0];
    assign carry  = arith & sum[WIDTH];
    assign ovf    = arith & (a[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD, OP_SUB: result = sum[WIDTH-1:0];
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  result = '0;
`endif
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered output stage.
// ALU_PIPE_MUL_EN adds an iterative radix-2 multiplier for opcode MUL.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_illegal
);
    logic             idle;
    logic             accept;
    logic             single;
    logic             mul_done;
    logic [WIDTH-1:0] c_result;
    logic [WIDTH-1:0] mul_result;
    logic [WIDTH-1:0] nxt_result;
    logic [TAG_W-1:0] mul_tag;
    logic             c_carry;
    logic             c_ovf;
    logic             c_illegal;
    alu_pipe_comb #(.WIDTH(WIDTH)) u_comb (
        .op(in_op), .a(in_a), .b(in_b),
        .result(c_result), .carry(c_carry), .ovf(c_ovf), .illegal(c_illegal)
    );
    assign in_ready = idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
`ifdef ALU_PIPE_MUL_EN
    localparam int CNT_W = shamt_w(WIDTH) < 6 ? 6 : shamt_w(WIDTH);
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    assign idle       = state == S_IDLE;
    assign single     = accept && in_op != OP_MUL;
    assign mul_done   = state == S_MUL && cnt == CNT_W'(WIDTH - 1);
    assign mul_result = acc + (mplier[0] ? mcand : '0);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            mul_tag <= '0;
        end else if (state == S_IDLE) begin
            if (accept && in_op == OP_MUL) begin
                state   <= S_MUL;
                cnt     <= '0;
                mcand   <= in_a;
                mplier  <= in_b;
                acc     <= '0;
                mul_tag <= in_tag;
            end
        end else begin
            acc    <= mul_result;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (mul_done) state <= S_IDLE;
        end
    end
`else
    assign idle       = 1'b1;
    assign single     = accept;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
    assign mul_tag    = '0;
`endif
    assign nxt_result = single ? c_result : mul_result;
    // MUL completion never collides with a load: accept is blocked while iterating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_zero    <= 1'b0;
            out_neg     <= 1'b0;
            out_carry   <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (single || mul_done) begin
            out_valid   <= 1'b1;
            out_result  <= nxt_result;
            out_tag     <= single ? in_tag : mul_tag;
            out_zero    <= nxt_result == '0;
            out_neg     <= nxt_result[WIDTH-1];
            out_carry   <= single & c_carry;
            out_ovf     <= single & c_ovf;
            out_illegal <= single & c_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=32, TAG_W=4).
module tb_alu_pipe;
    localparam int W = 32;
    localparam int T = 4;
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         il;
    } vec_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [T-1:0] in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic [T-1:0] out_tag;
    logic         out_zero;
    logic         out_neg;
    logic         out_carry;
    logic         out_ovf;
    logic         out_illegal;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    alu_pipe #(.WIDTH(W), .TAG_W(T)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_zero(out_zero), .out_neg(out_neg),
        .out_carry(out_carry), .out_ovf(out_ovf), .out_illegal(out_illegal)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [T-1:0] tag);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        checks++;
        if ({out_valid, out_zero, out_neg, out_carry, out_ovf, out_illegal} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {out_valid, out_zero, out_neg, out_carry, out_ovf, out_illegal});
        end
        checks++;
        if (out_result !== '0 || out_tag !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h exp=0/0", out_result, out_tag);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask
    task automatic test_back_to_back();
        vec_t vecs [16];
        vecs = '{
            '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0},
            '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0},
            '{4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0},
            '{4'h1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
            '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0},
            '{4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0},
            '{4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0},
            '{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0},
            '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0},
            '{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0},
            '{4'h7, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1'b0},
            '{4'h8, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 1'b0},
            '{4'h9, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1'b0},
            '{4'h9, 32'h7FFFFFF0, 32'hFFFFFFE4, 32'h07FFFFFF, 1'b0, 1'b0, 1'b0},
            '{4'hC, 32'h00001234, 32'h00005678, 32'h00000000, 1'b0, 1'b0, 1'b1},
            '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, T'(i));
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_tag !== T'(i) || out_result !== vecs[i].r) begin
                failures++;
                $display("FAIL op[%0d] valid=%b tag=%h result=%h exp 1/%h/%h", i, out_valid, out_tag, out_result, T'(i), vecs[i].r);
            end
            checks++;
            if ({out_zero, out_neg, out_carry, out_ovf, out_illegal} !==
                {vecs[i].r == '0, vecs[i].r[W-1], vecs[i].c, vecs[i].v, vecs[i].il}) begin
                failures++;
                $display("FAIL flags[%0d] got=%b exp=%b", i, {out_zero, out_neg, out_carry, out_ovf, out_illegal},
                         {vecs[i].r == '0, vecs[i].r[W-1], vecs[i].c, vecs[i].v, vecs[i].il});
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got=%b exp=0", out_valid);
        end
    endtask
    task automatic test_backpressure();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        drive(4'h0, 32'd1, 32'd2, 4'd1);
        out_ready = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd3 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_first valid=%b result=%h in_ready=%b exp 1/3/0", out_valid, out_result, in_ready);
        end
        drive(4'h0, 32'd10, 32'd20, 4'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'd3 || out_tag !== 4'd1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall[%0d] valid=%b result=%h tag=%h in_ready=%b exp 1/3/1/0", i, out_valid, out_result, out_tag, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got=%b exp=1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h1E || out_tag !== 4'd2) begin
            failures++;
            $display("FAIL bp_second valid=%b result=%h tag=%h exp 1/1e/2", out_valid, out_result, out_tag);
        end
        drive(4'h0, 32'd100, 32'd200, 4'd3);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h12C || out_tag !== 4'd3) begin
            failures++;
            $display("FAIL bp_third valid=%b result=%h tag=%h exp 1/12c/3", out_valid, out_result, out_tag);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got=%b exp=0", out_valid);
        end
    endtask
    task automatic test_mul();
        int  k;
        logic busy_ready;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
`ifdef ALU_PIPE_MUL_EN
        drive(4'hA, 32'h00012345, 32'h00000100, 4'd9);
        step();
        in_valid = 1'b0;
        k = 0;
        busy_ready = 1'b0;
        while (out_valid !== 1'b1 && k < 40) begin
            if (in_ready !== 1'b0) busy_ready = 1'b1;
            step();
            k++;
        end
        checks++;
        if (k != 32 || busy_ready) begin
            failures++;
            $display("FAIL mul_latency edges=%0d ready_seen=%b exp 32/0", k, busy_ready);
        end
        checks++;
        if (out_result !== 32'h01234500 || out_tag !== 4'd9 || {out_carry, out_ovf, out_illegal, out_zero} !== 4'b0) begin
            failures++;
            $display("FAIL mul_result result=%h tag=%h flags=%b exp 01234500/9/0000", out_result, out_tag, {out_carry, out_ovf, out_illegal, out_zero});
        end
        step();
        drive(4'hA, 32'h00012345, 32'h00000100, 4'd6);
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_reset valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        busy_ready = 1'b0;
        repeat (40) begin
            if (out_valid !== 1'b0) busy_ready = 1'b1;
            step();
        end
        checks++;
        if (busy_ready) begin
            failures++;
            $display("FAIL mul_reset_discard got=1 exp=0");
        end
`else
        drive(4'hA, 32'd3, 32'd4, 4'd5);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== '0 || out_tag !== 4'd5 || out_zero !== 1'b1 || out_illegal !== 1'b1) begin
            failures++;
            $display("FAIL mul_illegal valid=%b result=%h tag=%h zero=%b illegal=%b exp 1/0/5/1/1",
                     out_valid, out_result, out_tag, out_zero, out_illegal);
        end
        k = 0;
        busy_ready = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_illegal_drain valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
`endif
    endtask
    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised-width, handshaked successor to the single-cycle 3-bit-opcode ALU.
- Adds:
  - a 4-bit opcode space with SUB, SLTU and shift operations;
  - full NZCV-style flags;
  - a registered output stage with valid/ready backpressure;
  - an optional iterative multiplier.
- Sits between decode/issue and writeback in the multi-cycle core datapath.

Parameters:
- WIDTH, 32, operand/result width; power of 2, minimum 8.
- TAG_W, 4, width of the opaque sideband tag carried from input to output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_op  in  4  opcode (see Behaviour).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the op that produced out_result.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[WIDTH-1].
- out_carry  out  1  ADD: carry-out. SUB: carry-out of A+~B+1, so 1 means no borrow. All other ops: 0.
- out_ovf  out  1  signed overflow, ADD/SUB only; all other ops: 0.
- out_illegal  out  1  opcode not implemented; result forced to 0.

Behaviour:
- Opcodes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLT (signed, zero-extended to WIDTH); 0110 SLTU.
  - 0111 SLL; 1000 SRL; 1001 SRA.
  - 1010 MUL (low WIDTH bits of the product).
  - 1011-1111 illegal.
- Shift amount is in_b[$clog2(WIDTH)-1:0]; upper bits of in_b are ignored.
- Arithmetic is modulo 2^WIDTH. Flags are computed from the final result.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready); purely combinational from state.
  - out_* hold stable while out_valid && !out_ready.
- FSM states:
  - IDLE: accepting.
  - MUL: iterating.
- Single-cycle ops: accepted in cycle N → out_valid=1 with result in cycle N+1. Back-to-back throughput is 1/cycle when out_ready=1.
- MUL op, IDLE→MUL on accept:
  - Radix-2 shift-add: one multiplier bit per cycle; 6-bit-or-wider iteration counter runs 0..WIDTH-1.
  - After the last iteration: load output register, assert out_valid, return to IDLE.
  - Latency WIDTH+1 cycles; in_ready=0 throughout MUL.
  - The output register is always free at MUL completion, because accept requires the slot to drain.
- Reset, any state including mid-MUL:
  - state=IDLE, out_valid=0, out_result=0, out_tag=0, all flags 0.
  - Partial product discarded. in_ready=1 in the first cycle after reset deasserts.
- Simultaneous out_ready && in_valid while out_valid=1: old result drains and the new op is accepted on the same edge; no bubble.
- Illegal opcode: accepted normally; 1-cycle latency; out_result=0, out_zero=1, out_illegal=1.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined: MUL state, iteration counter and multiplicand/accumulator registers are present; opcode 1010 behaves as above.
- Undefined:
  - No MUL datapath and no MUL state; FSM reduces to IDLE only.
  - Opcode 1010 is treated as illegal: 1-cycle latency, result 0, out_illegal=1.

Decomposition:
- Package alu_pipe_pkg holds:
  - op_e enum (4-bit opcodes above);
  - state_e enum (IDLE, MUL);
  - localparam SHAMT_W = $clog2(WIDTH) as a function/macro helper.
- Natural sub-module: alu_pipe_comb. Purely combinational single-cycle datapath computing result and flags from op/a/b.
- alu_pipe keeps the FSM, the multiplier and the output register.

Test Plan:
- Reset then ADD, WIDTH=32: a=0x7FFFFFFF, b=1, tag=3 → next cycle out_result=0x80000000, neg=1, ovf=1, carry=0, out_tag=3.
- SUB a=5, b=5 → result=0, zero=1, carry=1. SLT a=0xFFFFFFFF, b=1 → 1. SLTU same operands → 0.
- SRA a=0x80000000, b=0x00000024 (shamt 4) → 0xF8000000. SRL with the same operands → 0x08000000.
- Backpressure: 3 back-to-back ADDs with out_ready held 0 for 4 cycles:
  - in_ready drops after the first accept.
  - out_result is stable while stalled.
  - All 3 results emerge in order, tags intact, once out_ready=1.
- MUL, macro defined: a=0x00012345, b=0x00000100 → out_valid exactly 33 cycles after accept, result=0x01234500, in_ready=0 meanwhile. Assert rst_n=0 at iteration 10 → out_valid=0, in_ready=1 the cycle after release.
- Opcode 1100, plus 1010 with the macro undefined → 1-cycle latency, result=0, zero=1, illegal=1.
